axi_llc_sram_data_ctrl: RTL and testbench

AXI_LLC_SRAM_DATA_CTRL -- requirements
Module: axi_llc_sram_data_ctrl

---
 rtl/axi_llc_pkg.sv | 19 +
 rtl/fifo_v3.sv | 79 +++++++
 rtl/axi_llc_sram_data_ctrl.sv | 132 +++++++++++++
 tb/tb_axi_llc_sram_data_ctrl.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_llc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axi_llc_pkg
// Purpose  : Shared constants and helpers for the LLC SRAM data path.
// Revision : 1.0 - initial release
// ============================================================================
package axi_llc_pkg;

  // Legal range of the data SRAM read latency in cycles.
  localparam int unsigned LlcSramLatencyMin = 1;
  localparam int unsigned LlcSramLatencyMax = 4;

  // Address width for an array of n entries, never narrower than one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_v3.sv
`default_nettype none
// ============================================================================
// Module   : fifo_v3
// Purpose  : Small synchronous FIFO with optional fall-through; any depth >= 2.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_v3 #(
  parameter bit          FALL_THROUGH = 1'b0,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH        = 8,
  localparam int unsigned PtrWidth    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  output logic                  full_o,
  output logic                  empty_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  push_i,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  pop_i
);

  localparam int unsigned CntWidth = $clog2(DEPTH + 1);

  logic [PtrWidth-1:0]   r_rd_ptr;
  logic [PtrWidth-1:0]   r_wr_ptr;
  logic [CntWidth-1:0]   r_cnt;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic w_stored_empty;
  logic w_bypass;
  logic w_do_push;
  logic w_do_pop;

  // Pointers wrap at DEPTH, which need not be a power of two.
  function automatic logic [PtrWidth-1:0] f_next(input logic [PtrWidth-1:0] p);
    return (p == PtrWidth'(DEPTH - 1)) ? '0 : p + PtrWidth'(1);
  endfunction

  assign w_stored_empty = (r_cnt == '0);
  assign full_o         = (r_cnt == CntWidth'(DEPTH));
  // In fall-through mode an incoming word makes the FIFO look non-empty at once.
  assign empty_o        = w_stored_empty & ~(FALL_THROUGH & push_i);
  // A word pushed and popped in the same cycle into an empty FIFO is never stored.
  assign w_bypass       = FALL_THROUGH & w_stored_empty & push_i & pop_i;
  assign w_do_push      = push_i & ~full_o & ~w_bypass;
  assign w_do_pop       = pop_i & ~w_stored_empty;
  assign data_o         = (FALL_THROUGH && w_stored_empty && push_i) ? data_i : r_mem[r_rd_ptr];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_cnt    <= '0;
    end else if (flush_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= f_next(r_wr_ptr);
      if (w_do_pop)  r_rd_ptr <= f_next(r_rd_ptr);
      if (w_do_push && !w_do_pop)      r_cnt <= r_cnt + CntWidth'(1);
      else if (!w_do_push && w_do_pop) r_cnt <= r_cnt - CntWidth'(1);
    end
  end

  // Storage array, cleared on reset so the output reads zero when idle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
    end else if (w_do_push) begin
      r_mem[r_wr_ptr] <= data_i;
    end
  end

endmodule
`default_nettype wire

// File: rtl/axi_llc_sram_data_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : axi_llc_sram_data_ctrl
// Purpose  : Single-port data SRAM front end. Requests go straight to the
//            SRAM; read data is captured after the SRAM latency into a
//            fall-through response FIFO. Credits bound outstanding reads so
//            the FIFO can never overflow.
// Revision : 1.0 - initial release
// ============================================================================
module axi_llc_sram_data_ctrl
  import axi_llc_pkg::*;
#(
  parameter int unsigned NumWords   = 1024,
  parameter int unsigned DataWidth  = 128,
  parameter int unsigned ByteWidth  = 8,
  parameter int unsigned Latency    = 1,
  localparam int unsigned AddrWidth = clog2_min1(NumWords),
  localparam int unsigned BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth,
  localparam int unsigned Depth     = Latency + 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_we_i,
  input  logic [AddrWidth-1:0] req_addr_i,
  input  logic [DataWidth-1:0] req_wdata_i,
  input  logic [BeWidth-1:0]   req_be_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [DataWidth-1:0] rsp_rdata_o,
  output logic                 sram_req_o,
  output logic                 sram_we_o,
  output logic [AddrWidth-1:0] sram_addr_o,
  output logic [DataWidth-1:0] sram_wdata_o,
  output logic [BeWidth-1:0]   sram_be_o,
  input  logic [DataWidth-1:0] sram_rdata_i
);

  typedef logic [AddrWidth-1:0] addr_t;
  typedef logic [DataWidth-1:0] data_t;
  typedef logic [BeWidth-1:0]   be_t;

  localparam int unsigned CreditWidth = $clog2(Depth + 1);
  typedef logic [CreditWidth-1:0] credit_t;

  logic         w_req_hs;
  logic         w_rd_acc;
  logic         w_wr_acc;
  logic         w_rsp_hs;
  logic         w_push;
  logic         w_fifo_full;
  logic         w_fifo_empty;
  addr_t        w_addr;
  data_t        w_wdata;
  be_t          w_be;

  credit_t      r_credits;
  logic [Latency-1:0] r_vld;

  assign w_req_hs = req_valid_i & req_ready_o;
  assign w_rd_acc = w_req_hs & ~req_we_i;
  assign w_wr_acc = w_req_hs & req_we_i;
  assign w_rsp_hs = rsp_valid_o & rsp_ready_i;

  // Writes never wait; reads need a credit, or one freed by a response this cycle.
  assign req_ready_o = req_we_i | (r_credits != '0) | w_rsp_hs;

  // SRAM port: idle (all zero) unless a request is accepted this cycle.
  assign w_addr       = w_req_hs ? req_addr_i  : '0;
  assign w_wdata      = w_wr_acc ? req_wdata_i : '0;
  assign w_be         = w_wr_acc ? req_be_i    : '0;
  assign sram_req_o   = w_req_hs;
  assign sram_we_o    = w_wr_acc;
  assign sram_addr_o  = w_addr;
  assign sram_wdata_o = w_wdata;
  assign sram_be_o    = w_be;

  // Credits count free response slots (in-flight reads plus buffered data).
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_credits <= credit_t'(Depth);
    end else if (w_rd_acc && !w_rsp_hs) begin
      r_credits <= r_credits - credit_t'(1);
    end else if (!w_rd_acc && w_rsp_hs) begin
      r_credits <= r_credits + credit_t'(1);
    end
  end

  // In-flight read tracker: the top bit marks SRAM data valid this cycle.
  if (Latency > 1) begin : g_vld_multi
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) r_vld <= '0;
      else         r_vld <= {r_vld[Latency-2:0], w_rd_acc};
    end
  end else begin : g_vld_single
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) r_vld <= '0;
      else         r_vld <= w_rd_acc;
    end
  end

  assign w_push      = r_vld[Latency-1];
  assign rsp_valid_o = ~w_fifo_empty;

  fifo_v3 #(
    .FALL_THROUGH (1'b1),
    .DATA_WIDTH   (DataWidth),
    .DEPTH        (Depth)
  ) u_rsp_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (1'b0),
    .full_o  (w_fifo_full),
    .empty_o (w_fifo_empty),
    .data_i  (sram_rdata_i),
    .push_i  (w_push),
    .data_o  (rsp_rdata_o),
    .pop_i   (w_rsp_hs)
  );

  a_latency_range: assert property (@(posedge clk_i)
    (Latency >= LlcSramLatencyMin) && (Latency <= LlcSramLatencyMax));
  a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
    w_push |-> !w_fifo_full);
  a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (w_rd_acc && !w_rsp_hs) |-> (r_credits != '0));
  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (!w_rd_acc && w_rsp_hs) |-> (r_credits != credit_t'(Depth)));

endmodule
`default_nettype wire

// File: tb/tb_axi_llc_sram_data_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_llc_sram_data_ctrl
// Purpose  : Scoreboard bench; three controllers with Latency 1, 2 and 3,
//            each attached to its own behavioural SRAM.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_llc_sram_data_ctrl;

  localparam int NW = 64;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam int AW = 6;
  localparam int NI = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [NI-1:0]         req_valid, req_ready, req_we, rsp_valid, rsp_ready;
  logic [NI-1:0]         sram_req, sram_we;
  logic [NI-1:0][AW-1:0] req_addr, sram_addr;
  logic [NI-1:0][DW-1:0] req_wdata, rsp_rdata, sram_wdata;
  logic [NI-1:0][BW-1:0] req_be, sram_be;

  logic [DW-1:0] exp_q [NI][$];
  int checks = 0;
  int errors = 0;
  int rsp_cnt   [NI];
  int first_rsp [NI];
  int last_rsp  [NI];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < NI; g++) begin : g_inst
    localparam int L = g + 1;
    logic [DW-1:0] mem  [NW];
    logic [DW-1:0] pipe [L];
    logic [DW-1:0] held;
    logic          held_v = 1'b0;

    initial begin
      for (int i = 0; i < NW; i++) mem[i] = 32'hC0DE_0000 | i;
      for (int i = 0; i < L; i++)  pipe[i] = 32'hDEAD_BEEF;
    end

    axi_llc_sram_data_ctrl #(
      .NumWords (NW), .DataWidth (DW), .ByteWidth (8), .Latency (L)
    ) u_dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .req_valid_i  (req_valid[g]),
      .req_ready_o  (req_ready[g]),
      .req_we_i     (req_we[g]),
      .req_addr_i   (req_addr[g]),
      .req_wdata_i  (req_wdata[g]),
      .req_be_i     (req_be[g]),
      .rsp_valid_o  (rsp_valid[g]),
      .rsp_ready_i  (rsp_ready[g]),
      .rsp_rdata_o  (rsp_rdata[g]),
      .sram_req_o   (sram_req[g]),
      .sram_we_o    (sram_we[g]),
      .sram_addr_o  (sram_addr[g]),
      .sram_wdata_o (sram_wdata[g]),
      .sram_be_o    (sram_be[g]),
      .sram_rdata_i (pipe[L-1])
    );

    // Behavioural SRAM with an L-cycle read pipeline; idle slots carry junk.
    always @(posedge clk) begin
      if (sram_req[g] && sram_we[g])
        for (int b = 0; b < BW; b++)
          if (sram_be[g][b]) mem[sram_addr[g]][b*8 +: 8] <= sram_wdata[g][b*8 +: 8];
      pipe[0] <= (sram_req[g] && !sram_we[g]) ? mem[sram_addr[g]] : 32'hDEAD_BEEF;
      for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end

    // Response monitor: pops the scoreboard on every response handshake.
    always @(negedge clk) begin
      if (!rst_n) begin
        held_v = 1'b0;
      end else begin
        if (held_v && rsp_valid[g]) chk($sformatf("rsp_stable_i%0d", g), rsp_rdata[g], held);
        if (rsp_valid[g] && rsp_ready[g]) begin
          if (exp_q[g].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rsp_unexpected_i%0d: got 0x%0h required no response", g, rsp_rdata[g]);
          end else begin
            chk($sformatf("rsp_data_i%0d", g), rsp_rdata[g], exp_q[g].pop_front());
          end
          rsp_cnt[g]++;
          if (first_rsp[g] < 0) first_rsp[g] = cyc;
          last_rsp[g] = cyc;
          held_v = 1'b0;
        end else if (rsp_valid[g]) begin
          held_v = 1'b1;
          held   = rsp_rdata[g];
        end else begin
          held_v = 1'b0;
        end
      end
    end
  end

  task automatic drive_idle(input int k);
    req_valid[k] = 1'b0;
    req_we[k]    = 1'b0;
    req_addr[k]  = '0;
    req_wdata[k] = '0;
    req_be[k]    = '0;
  endtask

  task automatic clr(input int k);
    rsp_cnt[k]   = 0;
    first_rsp[k] = -1;
    last_rsp[k]  = -1;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One request; hs_cyc is the monitor cycle number of the handshake cycle.
  task automatic issue(input int k, input bit we, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [BW-1:0] be,
                       input logic [DW-1:0] exp, output int hs_cyc, output int waits);
    int n = 0;
    req_valid[k] = 1'b1;
    req_we[k]    = we;
    req_addr[k]  = a;
    req_wdata[k] = d;
    req_be[k]    = be;
    @(negedge clk);
    while (!req_ready[k] && n < 64) begin
      n++;
      @(negedge clk);
    end
    hs_cyc = cyc;
    waits  = n;
    if (!req_ready[k]) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout_i%0d: req_ready 0 required 1", k);
    end else begin
      chk("sram_req", sram_req[k], 1);
      chk("sram_we", sram_we[k], we);
      if (!we) begin
        chk("rd_wdata_zero", sram_wdata[k], 0);
        chk("rd_be_zero", sram_be[k], 0);
      end
    end
    @(posedge clk);
    if (req_ready[k] && !we) exp_q[k].push_back(exp);
    #1;
    drive_idle(k);
  endtask

  // Holds a read request for `attempts` cycles, advancing the address per accept.
  task automatic burst(input int k, input logic [AW-1:0] base, input int attempts,
                       output int acc, output logic last_rdy);
    acc = 0;
    last_rdy = 1'b0;
    for (int i = 0; i < attempts; i++) begin
      req_valid[k] = 1'b1;
      req_we[k]    = 1'b0;
      req_addr[k]  = base + AW'(acc);
      @(negedge clk);
      last_rdy = req_ready[k];
      @(posedge clk);
      if (last_rdy) begin
        exp_q[k].push_back(32'hC0DE_0000 | (32'(base) + 32'(acc)));
        acc++;
      end
      #1;
    end
    drive_idle(k);
  endtask

  task automatic chk_reset_state(input int k);
    chk($sformatf("rst_req_ready_i%0d", k), req_ready[k], 1);
    chk($sformatf("rst_rsp_valid_i%0d", k), rsp_valid[k], 0);
    chk($sformatf("rst_sram_req_i%0d", k), sram_req[k], 0);
    chk($sformatf("rst_rsp_rdata_i%0d", k), rsp_rdata[k], 0);
  endtask

  initial begin
    int h, w, h0, wsum, acc;
    logic lr;
    for (int k = 0; k < NI; k++) begin
      drive_idle(k);
      rsp_ready[k] = 1'b1;
      clr(k);
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < NI; k++) chk_reset_state(k);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(2);

    // Latency 1: write then read back-to-back, response one cycle later.
    issue(0, 1'b1, 6'd5, 32'hA5A5_A5A5, 4'hF, '0, h, w);
    clr(0);
    issue(0, 1'b0, 6'd5, '0, '0, 32'hA5A5_A5A5, h, w);
    step(4);
    chk("l1_rsp_cycle", first_rsp[0], h + 1);
    chk("l1_rsp_cnt", rsp_cnt[0], 1);

    // Byte enables: only lane 0 of an all-ones write lands on a zero word.
    issue(0, 1'b1, 6'd7, 32'h0000_0000, 4'hF, '0, h, w);
    issue(0, 1'b1, 6'd7, 32'hFFFF_FFFF, 4'h1, '0, h, w);
    issue(0, 1'b0, 6'd7, '0, '0, 32'h0000_00FF, h, w);
    step(4);
    chk("be_q_empty", exp_q[0].size(), 0);

    // Latency 2 stall: only Depth=3 of 5 reads accepted while responses stall.
    clr(1);
    rsp_ready[1] = 1'b0;
    burst(1, 6'd20, 5, acc, lr);
    chk("stall_accepted", acc, 3);
    chk("stall_ready_low", lr, 0);
    step(3);
    chk("stall_no_rsp", rsp_cnt[1], 0);
    chk("stall_valid_held", rsp_valid[1], 1);
    // Writes still pass with zero credits; overwrite a word already in flight.
    issue(1, 1'b1, 6'd21, 32'h1234_5678, 4'hF, '0, h, w);
    chk("full_write_no_wait", w, 0);
    step(2);
    rsp_ready[1] = 1'b1;
    step(5);
    chk("stall_rsp_cnt", rsp_cnt[1], 3);
    chk("stall_q_empty", exp_q[1].size(), 0);
    issue(1, 1'b0, 6'd21, '0, '0, 32'h1234_5678, h, w);
    step(5);
    chk("raw_q_empty", exp_q[1].size(), 0);

    // Latency 3 throughput: 16 back-to-back reads, contiguous responses.
    clr(2);
    wsum = 0;
    h0 = 0;
    for (int i = 0; i < 16; i++) begin
      issue(2, 1'b0, AW'(30 + i), '0, '0, 32'hC0DE_0000 | (30 + i), h, w);
      if (i == 0) h0 = h;
      wsum += w;
    end
    step(8);
    chk("tp_no_wait", wsum, 0);
    chk("tp_first_rsp", first_rsp[2], h0 + 3);
    chk("tp_last_rsp", last_rsp[2], h0 + 3 + 15);
    chk("tp_rsp_cnt", rsp_cnt[2], 16);

    // Reset with two reads in flight: nothing stale may come out afterwards.
    issue(2, 1'b0, 6'd50, '0, '0, 32'hC0DE_0032, h, w);
    issue(2, 1'b0, 6'd51, '0, '0, 32'hC0DE_0033, h, w);
    rst_n = 1'b0;
    exp_q[2].delete();
    @(negedge clk);
    chk_reset_state(2);
    step(2);
    rst_n = 1'b1;
    clr(2);
    step(6);
    chk("rst_no_stale", rsp_cnt[2], 0);
    rsp_ready[2] = 1'b0;
    burst(2, 6'd52, 6, acc, lr);
    chk("rst_credits_depth", acc, 4);
    rsp_ready[2] = 1'b1;
    step(8);
    chk("rst_rsp_cnt", rsp_cnt[2], 4);
    chk("rst_q_empty", exp_q[2].size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
